// File: rtl/ace_interconnect_responder_if.sv
// ACE port bundle between a cache master and the interconnect responder.
// The slave modport is the responder side; the master modport is the cache side.
interface ace_interconnect_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // Read address and read data channels
    logic              AR_VALID;
    logic              AR_READY;
    logic [ADDR_W-1:0] AR_ADDR;
    logic [1:0]        AR_SNOOP;
    logic              R_VALID;
    logic              R_READY;
    logic [DATA_W-1:0] R_DATA;
    logic              R_okay;
    // Write address, write data and write response channels
    logic              AW_VALID;
    logic              AW_READY;
    logic [ADDR_W-1:0] AW_ADDR;
    logic              W_VALID;
    logic              W_READY;
    logic [DATA_W-1:0] W_DATA;
    logic              B_VALID;
    logic              B_READY;
    logic              B_okay;
    // Snoop request and snoop channels
    logic              snoop_req;
    logic [ADDR_W-1:0] snoop_addr;
    logic              AC_VALID;
    logic              AC_READY;
    logic [ADDR_W-1:0] AC_ADDR;
    logic              CR_VALID;
    logic              CR_READY;
    logic [1:0]        CR_RESP;
    logic              CD_VALID;
    logic              CD_READY;
    logic [DATA_W-1:0] CD_DATA;
    logic              snoop_busy;
    logic              snoop_done;

    modport slave (
        input  AR_VALID, AR_ADDR, AR_SNOOP, R_READY,
        input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
        input  snoop_req, snoop_addr, AC_READY, CR_VALID, CR_RESP, CD_VALID, CD_DATA,
        output AR_READY, R_VALID, R_DATA, R_okay,
        output AW_READY, W_READY, B_VALID, B_okay,
        output AC_VALID, AC_ADDR, CR_READY, CD_READY, snoop_busy, snoop_done
    );

    modport master (
        output AR_VALID, AR_ADDR, AR_SNOOP, R_READY,
        output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
        output snoop_req, snoop_addr, AC_READY, CR_VALID, CR_RESP, CD_VALID, CD_DATA,
        input  AR_READY, R_VALID, R_DATA, R_okay,
        input  AW_READY, W_READY, B_VALID, B_okay,
        input  AC_VALID, AC_ADDR, CR_READY, CD_READY, snoop_busy, snoop_done
    );
endinterface

// File: rtl/ace_interconnect_responder.sv
// Home-node end of an ACE port: serves ReadShared/MakeUnique reads and WriteClean
// writes from a small backing memory and issues snoops, absorbing dirty CD data.
// Optional macro ACE_RESP_BOUND_CHECK_EN: addresses >= MEM_WORDS get error responses
// and never touch memory; without it addresses wrap modulo MEM_WORDS.
module ace_interconnect_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 64,
    parameter int RESP_LAT  = 2
) (
    input logic                         clk,
    input logic                         rst,
    ace_interconnect_responder_if.slave bus
);

`ifdef ACE_RESP_BOUND_CHECK_EN
    localparam bit BOUND_CHECK = 1'b1;
`else
    localparam bit BOUND_CHECK = 1'b0;
`endif
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W = (RESP_LAT > 2) ? $clog2(RESP_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RESP_LAT - 1);

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_e;
    typedef enum logic [1:0] {WR_ADDR, WR_DATA, WR_WAIT, WR_RESP} wr_state_e;
    typedef enum logic [1:0] {SN_IDLE, SN_AC, SN_CR, SN_CD} sn_state_e;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return !BOUND_CHECK || (32'(a) < 32'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] mem_index(input logic [ADDR_W-1:0] a);
        return BOUND_CHECK ? IDX_W'(a) : IDX_W'(32'(a) % 32'(MEM_WORDS));
    endfunction

    logic [DATA_W-1:0] mem [MEM_WORDS];

    rd_state_e         rd_state_q, rd_state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        rd_snoop_q, rd_snoop_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_okay_q, r_okay_d;
    logic              rd_enter;
    logic [ADDR_W-1:0] smp_addr;
    logic [1:0]        smp_snoop;
    logic [IDX_W-1:0]  smp_idx;
    logic [DATA_W-1:0] smp_word;

    wr_state_e         wr_state_q, wr_state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              b_okay_q, b_okay_d;

    sn_state_e         sn_state_q, sn_state_d;
    logic [ADDR_W-1:0] ac_addr_q, ac_addr_d;
    logic              pass_dirty_q, pass_dirty_d;
    logic              snoop_done_q, snoop_done_d;

    logic              w_we, cd_we;
    logic [IDX_W-1:0]  w_idx, cd_idx;

    // Memory write ports: W commit from the write channel, dirty CD data from a snoop
    assign w_idx  = mem_index(wr_addr_q);
    assign w_we   = (wr_state_q == WR_DATA) && bus.W_VALID && addr_ok(wr_addr_q);
    assign cd_idx = mem_index(ac_addr_q);
    assign cd_we  = (sn_state_q == SN_CD) && bus.CD_VALID && pass_dirty_q && addr_ok(ac_addr_q);

    // Backing store; W is written last so it overrides CD on a same-address collision
    // NOTE: the memory array has no reset branch; contents are undefined after reset and
    // a reset port on a RAM would prevent block-RAM mapping and cost a clear sequence.
    always_ff @(posedge clk) begin
        if (cd_we) mem[cd_idx] <= bus.CD_DATA;
        if (w_we)  mem[w_idx]  <= bus.W_DATA;
    end

    // Read FSM next state; R payload is captured once on entry to RD_RESP
    // NOTE: every signal gets its default first so no path leaves one unassigned (no latch).
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_addr_d  = rd_addr_q;
        rd_snoop_d = rd_snoop_q;
        r_data_d   = r_data_q;
        r_okay_d   = r_okay_q;
        rd_enter   = 1'b0;
        smp_addr   = rd_addr_q;
        smp_snoop  = rd_snoop_q;
        smp_idx    = '0;
        smp_word   = '0;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (bus.AR_VALID) begin
                    rd_addr_d  = bus.AR_ADDR;
                    rd_snoop_d = bus.AR_SNOOP;
                    smp_addr   = bus.AR_ADDR;
                    smp_snoop  = bus.AR_SNOOP;
                    if (RESP_LAT <= 1) begin
                        rd_enter = 1'b1;
                    end else begin
                        rd_state_d = RD_WAIT;
                        rd_cnt_d   = LAT_LOAD;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_cnt_q <= CNT_W'(1)) rd_enter = 1'b1;
                else                       rd_cnt_d = rd_cnt_q - CNT_W'(1);
            end
            RD_RESP: begin
                if (bus.R_READY) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
        if (rd_enter) begin
            rd_state_d = RD_RESP;
            smp_idx    = mem_index(smp_addr);
            // A write committing on this same edge is forwarded so the read sees new data
            if (w_we && (w_idx == smp_idx))        smp_word = bus.W_DATA;
            else if (cd_we && (cd_idx == smp_idx)) smp_word = bus.CD_DATA;
            else                                   smp_word = mem[smp_idx];
            r_okay_d = 1'b0;
            r_data_d = '0;
            if (smp_snoop == 2'b01 || smp_snoop == 2'b10) r_okay_d = addr_ok(smp_addr);
            if (smp_snoop == 2'b01 && addr_ok(smp_addr))  r_data_d = smp_word;
        end
    end

    // Read FSM state and payload registers
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_addr_q  <= '0;
            rd_snoop_q <= '0;
            r_data_q   <= '0;
            r_okay_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_snoop_q <= rd_snoop_d;
            r_data_q   <= r_data_d;
            r_okay_q   <= r_okay_d;
        end
    end

    // Write FSM next state; AW and W are taken in separate states, never together
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_addr_d  = wr_addr_q;
        b_okay_d   = b_okay_q;
        unique case (wr_state_q)
            WR_ADDR: begin
                if (bus.AW_VALID) begin
                    wr_addr_d  = bus.AW_ADDR;
                    wr_state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus.W_VALID) begin
                    b_okay_d = addr_ok(wr_addr_q);
                    if (RESP_LAT <= 1) begin
                        wr_state_d = WR_RESP;
                    end else begin
                        wr_state_d = WR_WAIT;
                        wr_cnt_d   = LAT_LOAD;
                    end
                end
            end
            WR_WAIT: begin
                if (wr_cnt_q <= CNT_W'(1)) wr_state_d = WR_RESP;
                else                       wr_cnt_d   = wr_cnt_q - CNT_W'(1);
            end
            WR_RESP: begin
                if (bus.B_READY) wr_state_d = WR_ADDR;
            end
            default: wr_state_d = WR_ADDR;
        endcase
    end

    // Write FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= WR_ADDR;
            wr_cnt_q   <= '0;
            wr_addr_q  <= '0;
            b_okay_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_addr_q  <= wr_addr_d;
            b_okay_q   <= b_okay_d;
        end
    end

    // Snoop FSM next state; requests arriving while busy are dropped, not queued
    always_comb begin
        sn_state_d   = sn_state_q;
        ac_addr_d    = ac_addr_q;
        pass_dirty_d = pass_dirty_q;
        snoop_done_d = 1'b0;
        unique case (sn_state_q)
            SN_IDLE: begin
                if (bus.snoop_req) begin
                    ac_addr_d  = bus.snoop_addr;
                    sn_state_d = SN_AC;
                end
            end
            SN_AC: begin
                if (bus.AC_READY) sn_state_d = SN_CR;
            end
            SN_CR: begin
                if (bus.CR_VALID) begin
                    pass_dirty_d = bus.CR_RESP[1];
                    if (bus.CR_RESP[0]) begin
                        sn_state_d = SN_CD;
                    end else begin
                        sn_state_d   = SN_IDLE;
                        snoop_done_d = 1'b1;
                    end
                end
            end
            SN_CD: begin
                if (bus.CD_VALID) begin
                    sn_state_d   = SN_IDLE;
                    snoop_done_d = 1'b1;
                end
            end
            default: sn_state_d = SN_IDLE;
        endcase
    end

    // Snoop FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sn_state_q   <= SN_IDLE;
            ac_addr_q    <= '0;
            pass_dirty_q <= 1'b0;
            snoop_done_q <= 1'b0;
        end else begin
            sn_state_q   <= sn_state_d;
            ac_addr_q    <= ac_addr_d;
            pass_dirty_q <= pass_dirty_d;
            snoop_done_q <= snoop_done_d;
        end
    end

    assign bus.AR_READY   = (rd_state_q == RD_IDLE);
    assign bus.R_VALID    = (rd_state_q == RD_RESP);
    assign bus.R_DATA     = r_data_q;
    assign bus.R_okay     = r_okay_q;
    assign bus.AW_READY   = (wr_state_q == WR_ADDR);
    assign bus.W_READY    = (wr_state_q == WR_DATA);
    assign bus.B_VALID    = (wr_state_q == WR_RESP);
    assign bus.B_okay     = b_okay_q;
    assign bus.AC_VALID   = (sn_state_q == SN_AC);
    assign bus.AC_ADDR    = ac_addr_q;
    assign bus.CR_READY   = (sn_state_q == SN_CR);
    assign bus.CD_READY   = (sn_state_q == SN_CD);
    assign bus.snoop_busy = (sn_state_q != SN_IDLE);
    assign bus.snoop_done = snoop_done_q;

endmodule
